// File: rtl/tug_of_war_ctrl.sv
// tug_of_war_ctrl: game controller for the tug-of-war board.
// Consumes the arbiter verdict (push/tie/right), moves a one-hot rope marker one
// LED toward the first player, re-arms the arbiter with 'clear' after a release
// holdoff, and declares a winner when the marker reaches either end.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   push       arbiter: a player pressed first (async level)
//   tie        arbiter: both pressed together (async level)
//   right      arbiter: right player was first (async level)
//   pbl, pbr   raw left / right button levels (async)
//   new_game   synchronous pulse, restarts the game after a win
//   clear      re-arm level to the arbiter latches, active-high
//   led        one-hot marker position, bit 0 = left end
//   win        game over
//   win_right  valid with win: 1 = right player won
module tug_of_war_ctrl #(
  parameter int unsigned NPOS    = 9,
  parameter int unsigned CENTER  = (NPOS - 1) / 2,
  parameter int unsigned HOLDOFF = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            tie,
  input  logic            right,
  input  logic            pbl,
  input  logic            pbr,
  input  logic            new_game,
  output logic            clear,
  output logic [NPOS-1:0] led,
  output logic            win,
  output logic            win_right
);

  localparam int unsigned PW = (NPOS > 2) ? $clog2(NPOS) : 1;
  localparam int unsigned CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [NPOS-1:0] LED_CENTER = {{(NPOS - 1){1'b0}}, 1'b1} << CENTER;

  typedef enum logic [2:0] {
    S_READY,
    S_SETTLE,
    S_DECIDE,
    S_CLEAR,
    S_WIN
  } state_t;

  state_t         state;
  logic [PW-1:0]  pos;
  logic [CW-1:0]  cnt;
  logic [4:0]     sync1;
  logic [4:0]     sync2;

  // Synchronised views, order {push, tie, right, pbl, pbr}
  logic push_s, tie_s, right_s, pbl_s, pbr_s;
  assign {push_s, tie_s, right_s, pbl_s, pbr_s} = sync2;

  logic [PW-1:0] pos_inc;
  logic [PW-1:0] pos_dec;
  logic          quiet;

  // Neighbour positions and the "everything released" condition for the holdoff
  always_comb begin
    pos_inc = pos + PW'(1);
    pos_dec = pos - PW'(1);
    quiet   = ~(push_s | pbl_s | pbr_s);
  end

  // Synchronisers, game FSM and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      state     <= S_CLEAR;
      pos       <= PW'(CENTER);
      led       <= LED_CENTER;
      cnt       <= '0;
      clear     <= 1'b1;
      win       <= 1'b0;
      win_right <= 1'b0;
    end else begin
      sync1 <= {push, tie, right, pbl, pbr};
      sync2 <= sync1;
      case (state)
        S_READY: begin
          if (push_s) state <= S_SETTLE;
        end
        // Give tie_s one extra cycle to catch up with push_s
        S_SETTLE: begin
          state <= S_DECIDE;
        end
        S_DECIDE: begin
          clear <= 1'b1;
          cnt   <= '0;
          state <= S_CLEAR;
          if (!tie_s) begin
            if (right_s) begin
              pos <= pos_inc;
              led <= led << 1;
              if (pos_inc == PW'(NPOS - 1)) begin
                state     <= S_WIN;
                win       <= 1'b1;
                win_right <= 1'b1;
              end
            end else begin
              pos <= pos_dec;
              led <= led >> 1;
              if (pos_dec == '0) begin
                state     <= S_WIN;
                win       <= 1'b1;
                win_right <= 1'b0;
              end
            end
          end
        end
        // Re-arm only after HOLDOFF consecutive cycles with both buttons released
        S_CLEAR: begin
          if (quiet) begin
            if (cnt == CW'(HOLDOFF - 1)) begin
              state <= S_READY;
              clear <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        S_WIN: begin
          if (new_game) begin
            pos       <= PW'(CENTER);
            led       <= LED_CENTER;
            win       <= 1'b0;
            win_right <= 1'b0;
            cnt       <= '0;
            state     <= S_CLEAR;
          end
        end
        default: begin
          state <= S_CLEAR;
          clear <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Bench for tug_of_war_ctrl: directed vector table, hand sequences for async
// reset, and randomized play checked every cycle against a behavioural model.
module tb_tug_of_war_ctrl;

  localparam int unsigned NPOS    = 9;
  localparam int unsigned CENTER  = 4;
  localparam int unsigned HOLDOFF = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            push = 1'b0, tie = 1'b0, right = 1'b0;
  logic            pbl = 1'b0, pbr = 1'b0, new_game = 1'b0;
  logic            clear, win, win_right;
  logic [NPOS-1:0] led;

  int checks = 0;
  int errors = 0;

  tug_of_war_ctrl #(.NPOS(NPOS), .CENTER(CENTER), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .push(push), .tie(tie), .right(right),
    .pbl(pbl), .pbr(pbr), .new_game(new_game),
    .clear(clear), .led(led), .win(win), .win_right(win_right)
  );

  always #5 clk = ~clk;

  // Packed output view {led, win, win_right, clear}
  function automatic logic [11:0] outs();
    return {led, win, win_right, clear};
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got led=%h win=%b win_right=%b clear=%b, want led=%h win=%b win_right=%b clear=%b",
               name, got[11:3], got[2], got[1], got[0], exp[11:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Inputs reach the game logic through a two-deep delay line. A detected push
  // applies its move two cycles later; afterwards the arbiter stays cleared until
  // HOLDOFF consecutive fully-released cycles have been seen.
  bit [4:0] m_pipe1, m_pipe2;   // {push, tie, right, pbl, pbr}
  int       m_pos;
  bit       m_won, m_wr, m_clear;
  int       m_quiet;
  int       m_move;             // cycles until a pending move lands, 0 = none

  task automatic model_reset();
    m_pipe1 = '0; m_pipe2 = '0;
    m_pos = CENTER; m_won = 0; m_wr = 0; m_clear = 1; m_quiet = 0; m_move = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      if (m_won) begin
        if (new_game) begin
          m_pos = CENTER; m_won = 0; m_wr = 0; m_quiet = 0;
        end
      end else if (m_move == 1) begin
        if (!m_pipe2[3]) m_pos = m_pipe2[2] ? m_pos + 1 : m_pos - 1;
        m_clear = 1; m_quiet = 0; m_move = 0;
        if (m_pos == NPOS - 1) begin m_won = 1; m_wr = 1; end
        else if (m_pos == 0)   begin m_won = 1; m_wr = 0; end
      end else if (m_move == 2) begin
        m_move = 1;
      end else if (!m_clear) begin
        if (m_pipe2[4]) m_move = 2;
      end else begin
        if (m_pipe2[4] || m_pipe2[1] || m_pipe2[0]) m_quiet = 0;
        else if (m_quiet == HOLDOFF - 1) begin m_clear = 0; m_quiet = 0; end
        else m_quiet++;
      end
      m_pipe2 = m_pipe1;
      m_pipe1 = {push, tie, right, pbl, pbr};
    end
  end

  function automatic logic [11:0] model_outs();
    logic [NPOS-1:0] l;
    l = '0;
    l[m_pos] = 1'b1;
    return {l, m_won, m_wr, m_clear};
  endfunction

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst) check("model", outs(), model_outs());
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0]  in;    // {push, tie, right, pbl, pbr, new_game}
    int unsigned cyc;
    logic [11:0] exp;   // {led, win, win_right, clear}
  } vec_t;

  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] NG = 6'b000001;
  localparam logic [5:0] RM = 6'b101010;  // push, right, pbr
  localparam logic [5:0] LM = 6'b100100;  // push, pbl
  localparam logic [5:0] TM = 6'b110110;  // push, tie, both buttons
  localparam logic [5:0] HL = 6'b000100;  // pbl held alone

  vec_t tbl[$];

  function automatic vec_t v(input logic [5:0] i, input int unsigned c, input logic [8:0] l,
                             input logic w, input logic wr, input logic cl);
    vec_t r;
    r.in = i; r.cyc = c; r.exp = {l, w, wr, cl};
    return r;
  endfunction

  task automatic drive(input logic [5:0] i);
    {push, tie, right, pbl, pbr, new_game} = i;
  endtask

  task automatic run_cycles(input logic [5:0] i, input int unsigned n);
    drive(i);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset and holdoff from power-up
    tbl.push_back(v(Z, 15, 9'h010, 0, 0, 1));
    tbl.push_back(v(Z, 1,  9'h010, 0, 0, 0));
    tbl.push_back(v(Z, 4,  9'h010, 0, 0, 0));
    tbl.push_back(v(NG, 1, 9'h010, 0, 0, 0));   // new_game ignored outside WIN
    // right move and its latency
    tbl.push_back(v(RM, 3, 9'h010, 0, 0, 0));
    tbl.push_back(v(RM, 2, 9'h020, 0, 0, 1));
    tbl.push_back(v(Z, 17, 9'h020, 0, 0, 1));
    tbl.push_back(v(Z, 1,  9'h020, 0, 0, 0));
    // tie: no move, same clear/holdoff sequence
    tbl.push_back(v(TM, 5, 9'h020, 0, 0, 1));
    tbl.push_back(v(Z, 17, 9'h020, 0, 0, 1));
    tbl.push_back(v(Z, 1,  9'h020, 0, 0, 0));
    // left moves, second with a long held button
    tbl.push_back(v(LM, 5, 9'h010, 0, 0, 1));
    tbl.push_back(v(Z, 18, 9'h010, 0, 0, 0));
    tbl.push_back(v(LM, 5, 9'h008, 0, 0, 1));
    tbl.push_back(v(HL, 100, 9'h008, 0, 0, 1));
    tbl.push_back(v(Z, 17, 9'h008, 0, 0, 1));
    tbl.push_back(v(Z, 1,  9'h008, 0, 0, 0));
    // walk right to a right win
    tbl.push_back(v(RM, 5, 9'h010, 0, 0, 1));
    tbl.push_back(v(Z, 18, 9'h010, 0, 0, 0));
    tbl.push_back(v(RM, 5, 9'h020, 0, 0, 1));
    tbl.push_back(v(Z, 18, 9'h020, 0, 0, 0));
    tbl.push_back(v(RM, 5, 9'h040, 0, 0, 1));
    tbl.push_back(v(Z, 18, 9'h040, 0, 0, 0));
    tbl.push_back(v(RM, 5, 9'h080, 0, 0, 1));
    tbl.push_back(v(Z, 18, 9'h080, 0, 0, 0));
    tbl.push_back(v(RM, 5, 9'h100, 1, 1, 1));
    // frozen in WIN
    tbl.push_back(v(RM, 5, 9'h100, 1, 1, 1));
    tbl.push_back(v(Z, 18, 9'h100, 1, 1, 1));
    tbl.push_back(v(LM, 5, 9'h100, 1, 1, 1));
    tbl.push_back(v(Z, 30, 9'h100, 1, 1, 1));
    // restart
    tbl.push_back(v(NG, 1, 9'h010, 0, 0, 1));
    tbl.push_back(v(Z, 15, 9'h010, 0, 0, 1));
    tbl.push_back(v(Z, 1,  9'h010, 0, 0, 0));
    // walk left to a left win
    tbl.push_back(v(LM, 5, 9'h008, 0, 0, 1));
    tbl.push_back(v(Z, 18, 9'h008, 0, 0, 0));
    tbl.push_back(v(LM, 5, 9'h004, 0, 0, 1));
    tbl.push_back(v(Z, 18, 9'h004, 0, 0, 0));
    tbl.push_back(v(LM, 5, 9'h002, 0, 0, 1));
    tbl.push_back(v(Z, 18, 9'h002, 0, 0, 0));
    tbl.push_back(v(LM, 5, 9'h001, 1, 0, 1));
    tbl.push_back(v(Z, 20, 9'h001, 1, 0, 1));
    tbl.push_back(v(NG, 1, 9'h010, 0, 0, 1));
    tbl.push_back(v(Z, 16, 9'h010, 0, 0, 0));

    // power-up reset
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("reset_state", outs(), {9'h010, 1'b0, 1'b0, 1'b1});

    foreach (tbl[i]) begin
      run_cycles(tbl[i].in, tbl[i].cyc);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // async reset mid-CLEAR with the marker at 9'h004
    run_cycles(LM, 5);
    run_cycles(Z, 18);
    run_cycles(LM, 5);
    run_cycles(Z, 3);
    check("pre_reset_pos", outs(), {9'h004, 1'b0, 1'b0, 1'b1});
    #2 rst = 1'b0;
    #1 check("async_reset", outs(), {9'h010, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (16) @(negedge clk);
    check("post_reset_ready", outs(), {9'h010, 1'b0, 1'b0, 1'b0});

    // randomized play, checked by the model every cycle
    for (int n = 0; n < 400; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        run_cycles(Z, $urandom_range(1, 24));
      end else if (kind < 5) begin
        run_cycles(NG, 1);
      end else begin
        logic [5:0] r;
        r = 6'($urandom) & 6'b111110;
        run_cycles(r, $urandom_range(1, 8));
      end
    end
    run_cycles(Z, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
